clock_freq_meter: RTL and testbench

- Measures a slow periodic signal, such as the 64 Hz timer tick, against the system clock.
- Reports the period and high time, in system-clock cycles, of each completed cycle of the signal.
- This is the receiving/checking end of the timer's clock-divider outputs.
- Used for self-check of divider outputs and for measuring external slow clocks; detects a stalled input via timeout.

---
 rtl/clock_freq_meter.sv | 145 ++++++++++++++
 tb/tb_clock_freq_meter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clock_freq_meter.sv
// clock_freq_meter
//
// Measures a slow periodic signal (e.g. a divided timer tick) against the
// system clock. Each completed cycle of sig_in is reported as its period and
// high time, both counted in clk cycles. A missing rising edge for TIMEOUT
// cycles drops lock and raises a sticky timeout flag.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sig_in     measured signal, asynchronous to clk
//   period     clk cycles between the last two rising edges
//   high_time  clk cycles from rising to falling edge within that period
//   valid      one-cycle pulse when period/high_time update
//   locked     high while measurements are current
//   timeout    sticky: no rising edge within TIMEOUT cycles
module clock_freq_meter #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_lat;
  logic             take_meas;
  logic             do_timeout;

  // s1/s2 resynchronise sig_in; s3 is one cycle older so edges are
  // detected on the synchronised copy only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  // cnt never exceeds TIMEOUT-1, so cnt+1 always fits in CNT_W bits.
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A rise in MEASURE always completes a measurement, even when the counter
  // is at its last value in the same cycle; only a rise-free expiry times out.
  always_comb begin
    state_next = state;
    take_meas  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          take_meas = 1'b1;
        end else if (cnt == CNT_LAST) begin
          do_timeout = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counter restarts on every rise so that cnt+1 at the next rise equals the
  // period. hi_lat is cleared on each rise so a cycle without a fall reports
  // a high time of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= take_meas;

      if (state == MEASURE && !rise && !do_timeout) begin
        cnt <= cnt_inc;
      end else begin
        cnt <= '0;
      end

      if (rise || do_timeout) begin
        hi_lat <= '0;
      end else if (state == MEASURE && fall) begin
        hi_lat <= cnt_inc;
      end

      if (take_meas) begin
        period    <= cnt_inc;
        high_time <= hi_lat;
        locked    <= 1'b1;
        timeout   <= 1'b0;
      end else if (do_timeout) begin
        period    <= '0;
        high_time <= '0;
        locked    <= 1'b0;
        timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_freq_meter.sv
// tb_clock_freq_meter
//
// Directed bench for clock_freq_meter with CNT_W=8, TIMEOUT=100. A monitor
// records every valid pulse (count, spacing, reported values); the main
// sequence drives sig_in a full period at a time and compares against
// hand-computed values.
module tb_clock_freq_meter;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 100;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  int checks   = 0;
  int failures = 0;

  int               cyc            = 0;
  int               valid_cnt      = 0;
  int               last_valid_cyc = 0;
  int               gap            = 0;
  int               timeout_cycles = 0;
  logic [CNT_W-1:0] last_period    = '0;
  logic [CNT_W-1:0] last_high      = '0;

  int vc;
  int tc;

  clock_freq_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .locked   (locked),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt      = valid_cnt + 1;
      gap            = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
      last_period    = period;
      last_high      = high_time;
    end
    if (timeout === 1'b1) timeout_cycles = timeout_cycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      failures = failures + 1;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full period of sig_in: h cycles high, then p-h cycles low.
  task automatic applyStimulus(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(posedge clk);
      #1 sig_in = (i < h);
    end
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    rst_n  = 1'b0;
    sig_in = 1'b0;
    waitNeg(3);
    checkOutput("rst_period", 32'(period), 0);
    checkOutput("rst_high", 32'(high_time), 0);
    checkOutput("rst_valid", 32'(valid), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;

    // Input stuck low from reset: stays idle, never times out
    waitNeg(150);
    checkOutput("idle_timeout", 32'(timeout), 0);
    checkOutput("idle_locked", 32'(locked), 0);
    checkOutput("idle_valid_cnt", 32'(valid_cnt), 0);

    // 20/5 wave: first rise only arms
    applyStimulus(20, 5);
    checkOutput("arm_valid_cnt", 32'(valid_cnt), 0);
    checkOutput("arm_locked", 32'(locked), 0);
    applyStimulus(20, 5);
    checkOutput("first_valid_cnt", 32'(valid_cnt), 1);
    checkOutput("first_period", 32'(last_period), 20);
    checkOutput("first_high", 32'(last_high), 5);
    checkOutput("first_locked", 32'(locked), 1);
    checkOutput("first_timeout", 32'(timeout), 0);
    repeat (3) applyStimulus(20, 5);
    checkOutput("w20_valid_cnt", 32'(valid_cnt), 4);
    checkOutput("w20_gap", 32'(gap), 20);
    checkOutput("w20_period", 32'(period), 20);
    checkOutput("w20_high", 32'(high_time), 5);

    // Switch to 37/30: first valid reports the last 20/5 cycle
    applyStimulus(37, 30);
    checkOutput("tr_valid_cnt", 32'(valid_cnt), 5);
    checkOutput("tr_period", 32'(last_period), 20);
    checkOutput("tr_high", 32'(last_high), 5);
    repeat (3) applyStimulus(37, 30);
    checkOutput("w37_valid_cnt", 32'(valid_cnt), 8);
    checkOutput("w37_gap", 32'(gap), 37);
    checkOutput("w37_period", 32'(last_period), 37);
    checkOutput("w37_high", 32'(last_high), 30);

    // Hold low: rise registered 3 edges into the last period, timeout
    // exactly 100 edges after that
    vc = valid_cnt;
    waitNeg(67);
    checkOutput("pre_to_timeout", 32'(timeout), 0);
    checkOutput("pre_to_locked", 32'(locked), 1);
    waitNeg(1);
    checkOutput("to_timeout", 32'(timeout), 1);
    checkOutput("to_locked", 32'(locked), 0);
    checkOutput("to_period", 32'(period), 0);
    checkOutput("to_high", 32'(high_time), 0);
    waitNeg(20);
    checkOutput("to_no_valid", 32'(valid_cnt), 32'(vc));
    checkOutput("to_sticky", 32'(timeout), 1);

    // Resume: arming does not clear timeout
    applyStimulus(20, 5);
    checkOutput("rearm_timeout", 32'(timeout), 1);
    checkOutput("rearm_valid_cnt", 32'(valid_cnt), 32'(vc));
    applyStimulus(20, 5);
    checkOutput("resume_valid_cnt", 32'(valid_cnt), 32'(vc + 1));
    checkOutput("resume_period", 32'(last_period), 20);
    checkOutput("resume_high", 32'(last_high), 5);
    checkOutput("resume_timeout", 32'(timeout), 0);
    checkOutput("resume_locked", 32'(locked), 1);

    // Asynchronous reset mid-period
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 sig_in = (i < 5);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_period", 32'(period), 0);
    checkOutput("arst_high", 32'(high_time), 0);
    checkOutput("arst_locked", 32'(locked), 0);
    checkOutput("arst_valid", 32'(valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vc = valid_cnt;
    applyStimulus(20, 5);
    checkOutput("post_rst_arm", 32'(valid_cnt), 32'(vc));
    applyStimulus(20, 5);
    checkOutput("post_rst_valid_cnt", 32'(valid_cnt), 32'(vc + 1));
    checkOutput("post_rst_period", 32'(last_period), 20);

    // Period equal to TIMEOUT: the rise lands on cnt == TIMEOUT-1 and wins
    vc = valid_cnt;
    tc = timeout_cycles;
    repeat (3) applyStimulus(100, 50);
    checkOutput("edge_valid_cnt", 32'(valid_cnt), 32'(vc + 3));
    checkOutput("edge_period", 32'(last_period), 100);
    checkOutput("edge_high", 32'(last_high), 50);
    checkOutput("edge_gap", 32'(gap), 100);
    checkOutput("edge_no_timeout", 32'(timeout_cycles), 32'(tc));
    checkOutput("edge_locked", 32'(locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
